mem_access_16b: RTL and testbench
=================================

# mem_access_16b

Load/store unit directly downstream of the 16-bit ALU. It takes the effective address (the ALU `mar_val`) and store data (the ALU `mem_data`), and runs one 8- or 16-bit access on the 8-bit external bus. A 16-bit access is split into two little-endian byte cycles. The assembled load word is returned on `rdata`, which the sequencer routes to the ALU `t16` input.

## Interface

- `TIMEOUT`, default 0: maximum cycles one byte phase may wait for `bus_ack`; 0 disables the timeout.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: sequencer presents an access.
- `req_ready` output 1: unit can accept; high only in IDLE and not in reset.
- `req_we` input 1: 1 = store, 0 = load.
- `req_wide` input 1: 1 = 16-bit access, 0 = 8-bit access.
- `addr` input 16: byte address (from ALU `mar_val`).
- `wdata` input 16: store data (from ALU `mem_data`); only [7:0] is used when `req_wide`=0.
- `rdata` output 16: last completed load value.
- `done` output 1: one-cycle pulse when an access completes successfully.
- `err` output 1: one-cycle pulse when an access is aborted by timeout.
- `bus_req` output 1: external byte cycle request.
- `bus_we` output 1: external write strobe, valid while `bus_req`=1.
- `bus_addr` output 16: external byte address.
- `bus_wdata` output 8: external write byte.
- `bus_rdata` input 8: external read byte; sampled when `bus_ack`=1.
- `bus_ack` input 1: byte cycle completes in any cycle where `bus_req`=1 and `bus_ack`=1.

## Operation

- States: IDLE, LO, HI, FIN.
- IDLE: `req_ready`=1. On `req_valid`=1, latch `addr`, `wdata`, `req_we`, `req_wide` and go to LO. Request inputs are not sampled in any other state.
- LO: `bus_req`=1, `bus_addr`=latched addr, `bus_wdata`=wdata[7:0].
  - On ack, a load captures `bus_rdata` into the low byte of a staging register.
  - Next state is HI if wide, otherwise FIN.
- HI: `bus_req`=1, `bus_addr`=addr+1 (16-bit wrap, so 0xFFFF+1 = 0x0000), `bus_wdata`=wdata[15:8].
  - On ack, a load captures the high byte; next state is FIN.
- FIN: `done`=1 for exactly this cycle. For a load, `rdata` is updated from the staging register on entry to FIN.
  - 8-bit loads zero-extend: [15:8]=0. Sign extension is left to the ALU EXT function.
  - Next state is IDLE.
- `rdata` holds its value across stores, errors and idle cycles. It changes only when a load completes.
- Without an ack, LO and HI hold all bus outputs stable.
- Timeout (when `TIMEOUT`>0):
  - A per-phase wait counter clears on entry to LO and HI and increments each cycle without ack.
  - When the counter reaches `TIMEOUT` with no ack: drop `bus_req` the next cycle, pulse `err` for one cycle, return to IDLE.
  - No `done` is produced and `rdata` is unchanged.
- `bus_ack` while `bus_req`=0 is ignored.
- Reset values: state IDLE, `req_ready`=0 while `rst` is high (1 the cycle after release), `rdata`=0x0000, `done`=0, `err`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0x0000, `bus_wdata`=0x00.
- Reset mid-access: the bus cycle is abandoned and `bus_req`=0 on the first cycle after the reset edge. No `done`/`err`; `rdata` is cleared.

## Timing

- Acceptance in cycle 0 (IDLE, `req_valid`=1). `bus_req` rises in cycle 1.
- Zero-wait bus (ack in the same cycle as req):
  - 8-bit: LO in cycle 1, `done` in cycle 2.
  - 16-bit: LO in cycle 1, HI in cycle 2, `done` in cycle 3.
- Each wait cycle adds one cycle to its phase.
- `req_ready` returns to 1 in the cycle after FIN. Back-to-back throughput is therefore one access per 3 cycles (8-bit) or 4 cycles (16-bit).
- `rdata` is valid in the same cycle `done` pulses; the sequencer may load the ALU `t16` input in that cycle.
- `bus_we` equals the latched `req_we` throughout LO and HI, and is 0 otherwise.
- Timeout example with `TIMEOUT`=3, no ack: LO in cycles 1-3, `err` in cycle 4, IDLE in cycle 5.

## Test plan

- **16-bit load, zero wait.** Memory [0x1000]=0x34, [0x1001]=0x12; `req_valid` with `addr`=0x1000, `req_wide`=1, `req_we`=0. Expect bus addrs 0x1000 then 0x1001, `done` in cycle 3, `rdata`=0x1234.
- **8-bit load, zero-extend.** [0x2000]=0xF0, `req_wide`=0. Expect a single bus cycle, `done` in cycle 2, `rdata`=0x00F0.
- **16-bit store with wrap and wait states.** `addr`=0xFFFF, `wdata`=0xBEEF; ack delayed 2 cycles per phase. Expect bus writes 0xEF@0xFFFF then 0xBE@0x0000, outputs stable during waits, `done` in cycle 7, `rdata` unchanged.
- **Timeout.** `TIMEOUT`=3, ack never given. Expect `err` pulse in cycle 4, no `done`, `bus_req`=0 from cycle 4, `req_ready`=1 in cycle 5.
- **Reset mid-access.** Assert `rst` during HI of a 16-bit load. Expect `bus_req`=0, `rdata`=0x0000 and `done`=0 after the edge, `req_ready`=1 the cycle after `rst` drops.
- **Spurious and back-to-back.** Drive `bus_ack`=1 while idle: no state change. Hold `req_valid` for two queued 8-bit loads: accepted in cycles 0 and 3, `done` in cycles 2 and 5.

Source files
------------

// File: rtl/mem_access_16b.sv
// Load/store unit: turns one 8- or 16-bit access into little-endian byte
// cycles on the 8-bit external bus, with an optional per-phase ack timeout.
module mem_access_16b #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_wide,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIN,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          we_q;
    logic          wide_q;
    logic [7:0]    stage_lo;
    logic [CW-1:0] wait_cnt;
    logic          in_phase;
    logic          timed_out;

    assign in_phase = (state == LO) || (state == HI);

    // Abort once this cycle would be the TIMEOUT-th consecutive unacked cycle.
    assign timed_out = (TIMEOUT != 0) && !bus_ack && (wait_cnt == LIMIT);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req_valid) state_n = LO;
            LO: begin
                if (bus_ack)        state_n = wide_q ? HI : FIN;
                else if (timed_out) state_n = ERR;
            end
            HI: begin
                if (bus_ack)        state_n = FIN;
                else if (timed_out) state_n = ERR;
            end
            FIN:     state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        done      = (state == FIN);
        err       = (state == ERR);
        bus_req   = in_phase;
        bus_we    = in_phase && we_q;
        bus_addr  = '0;
        bus_wdata = '0;
        if (state == LO) begin
            bus_addr  = addr_q;
            bus_wdata = wdata_q[7:0];
        end else if (state == HI) begin
            bus_addr  = addr_q + 16'd1;
            bus_wdata = wdata_q[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wide_q   <= 1'b0;
            stage_lo <= '0;
            rdata    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= req_we;
                wide_q  <= req_wide;
            end
            // rdata is written on the ack that ends the last phase, so it is
            // already valid in the FIN cycle.
            if (state == LO && bus_ack && !we_q) begin
                stage_lo <= bus_rdata;
                if (!wide_q) rdata <= {8'h00, bus_rdata};
            end
            if (state == HI && bus_ack && !we_q) begin
                rdata <= {bus_rdata, stage_lo};
            end
            if (in_phase && !bus_ack) wait_cnt <= wait_cnt + 1'b1;
            else                      wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_16b.sv
// Self-checking bench for mem_access_16b: directed scenarios plus random
// accesses checked against a byte-array memory model.
module tb_mem_access_16b;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_wide;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    mem_access_16b #(.TIMEOUT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wide  (req_wide),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0]  mem [65536];
    logic [15:0] model_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete access with w0/w1 wait cycles before the ack of each phase.
    task automatic access(input logic we, input logic wide, input logic [15:0] a,
                          input logic [15:0] wd, input int w0, input int w1);
        logic [15:0] a1;
        a1 = a + 16'd1;
        chk("acc_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_wide = wide; addr = a; wdata = wd;
        step();
        req_valid = 1'b0; req_we = 1'($urandom); req_wide = 1'($urandom);
        addr = 16'($urandom); wdata = 16'($urandom);
        for (int p = 0; p < (wide ? 2 : 1); p++) begin
            logic [15:0] pa;
            logic [7:0]  pb;
            int          w;
            pa = (p == 0) ? a : a1;
            pb = (p == 0) ? wd[7:0] : wd[15:8];
            w  = (p == 0) ? w0 : w1;
            for (int i = 0; i <= w; i++) begin
                chk("bus_req", bus_req, 1);
                chk("bus_addr", bus_addr, pa);
                chk("bus_we", bus_we, we);
                if (we) chk("bus_wdata", bus_wdata, pb);
                chk("done_early", done, 0);
                chk("err_phase", err, 0);
                bus_ack   = (i == w);
                bus_rdata = (i == w) ? mem[pa] : 8'($urandom);
                if (i == w && we) mem[pa] = pb;
                step();
                bus_ack = 1'b0;
            end
        end
        if (!we) model_rdata = wide ? {mem[a1], mem[a]} : {8'h00, mem[a]};
        chk("done", done, 1);
        chk("err_fin", err, 0);
        chk("bus_req_fin", bus_req, 0);
        chk("rdata", rdata, model_rdata);
        chk("ready_fin", req_ready, 0);
        step();
        chk("done_clr", done, 0);
        chk("ready_back", req_ready, 1);
        chk("rdata_hold", rdata, model_rdata);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12; mem[16'h2000] = 8'hF0;
        model_rdata = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
        addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 16'h0000);
        chk("rst_bus_wdata", bus_wdata, 8'h00);
        rst = 1'b0;
        step();
        chk("ready_after_rst", req_ready, 1);

        access(1'b0, 1'b1, 16'h1000, 16'h0000, 0, 0);
        chk("load16_value", rdata, 16'h1234);
        access(1'b0, 1'b0, 16'h2000, 16'h0000, 0, 0);
        chk("load8_zext", rdata, 16'h00F0);
        access(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 2, 2);
        chk("store_keeps_rdata", rdata, 16'h00F0);
        access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1, 0);
        chk("wrap_readback", rdata, 16'hBEEF);

        // Timeout: accepted in cycle 0, LO in 1-3, err in 4, ready in 5.
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b1; addr = 16'h3000;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("to_bus_req", bus_req, 1);
            chk("to_err_early", err, 0);
            step();
        end
        chk("to_err", err, 1);
        chk("to_done", done, 0);
        chk("to_bus_req_drop", bus_req, 0);
        chk("to_ready_busy", req_ready, 0);
        step();
        chk("to_err_clr", err, 0);
        chk("to_ready", req_ready, 1);
        chk("to_rdata", rdata, model_rdata);

        // Reset during HI of a 16-bit load.
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b1; addr = 16'h1000;
        step();
        req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h55;
        step();
        bus_ack = 1'b0;
        chk("mid_in_hi", bus_addr, 16'h1001);
        rst = 1'b1;
        step();
        model_rdata = '0;
        chk("mid_bus_req", bus_req, 0);
        chk("mid_rdata", rdata, 16'h0000);
        chk("mid_done", done, 0);
        chk("mid_ready_rst", req_ready, 0);
        rst = 1'b0;
        step();
        chk("mid_ready", req_ready, 1);

        // Ack while idle must be ignored.
        bus_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus_rdata = 8'($urandom);
            step();
            chk("spur_bus_req", bus_req, 0);
            chk("spur_done", done, 0);
            chk("spur_ready", req_ready, 1);
            chk("spur_rdata", rdata, 16'h0000);
        end
        bus_ack = 1'b0;

        // req_valid held: accepts in cycles 0 and 3, done in 2 and 5.
        req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; addr = 16'h2000;
        step();
        addr = 16'h1001;
        chk("b2b_addr0", bus_addr, 16'h2000);
        bus_ack = 1'b1; bus_rdata = mem[16'h2000];
        step();
        bus_ack = 1'b0;
        chk("b2b_done0", done, 1);
        chk("b2b_rdata0", rdata, 16'h00F0);
        step();
        chk("b2b_ready3", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_addr1", bus_addr, 16'h1001);
        bus_ack = 1'b1; bus_rdata = mem[16'h1001];
        step();
        bus_ack = 1'b0;
        chk("b2b_done1", done, 1);
        chk("b2b_rdata1", rdata, 16'h0012);
        step();
        model_rdata = 16'h0012;

        for (int n = 0; n < 60; n++) begin
            logic [15:0] ra;
            ra = (n % 10 == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
            access(1'($urandom), 1'($urandom), ra, 16'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
